// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO-side signal bundle for the FIFO write arbiter.
// Handshake: producer k holds req[k] with stable data until ack[k]; a beat transfers in the cycle req[k] && ack[k].
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          wr_en;
  logic [FIFO_WIDTH-1:0]         data_in;
  logic [IW-1:0]                 grant_id;
  logic                          busy;

  modport master (
    output req, req_data, fifo_full, fifo_almostfull,
    input  ack, wr_en, data_in, grant_id, busy
  );

  modport slave (
    input  req, req_data, fifo_full, fifo_almostfull,
    output ack, wr_en, data_in, grant_id, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter with burst locking sharing one FIFO write port among NUM_REQ producers.
// Writes are registered one cycle after ack and never issued into a full FIFO.
module fifo_write_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int FIFO_WIDTH = 16,
  parameter  int MAX_BURST  = 4,
  localparam int IW         = $clog2(NUM_REQ),
  localparam int CW         = $clog2(MAX_BURST + 1)
) (
  input  logic                clk,
  input  logic                rst,
  fifo_write_arbiter_if.slave bus,
  output logic                dbg_state_o,
  output logic [CW-1:0]       dbg_burst_cnt_o,
  output logic [IW-1:0]       dbg_rr_ptr_o
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         grant_id_q, grant_id_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0] data_in_q, data_in_d;

  logic          hold;
  logic          can_accept;
  logic          accept;
  logic [IW-1:0] owner;
  logic [IW-1:0] scan_owner;
  logic [IW-1:0] scan_idx;
  logic          found;

  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    else return i + IW'(1);
  endfunction

  // A write already in flight consumes the last slot flagged by almostfull.
  assign can_accept = !bus.fifo_full && !(wr_en_q && bus.fifo_almostfull);
  assign hold       = (state_q == BURST) && bus.req[grant_id_q];
  assign owner      = hold ? grant_id_q : scan_owner;
  assign accept     = (|bus.req) && can_accept && !rst;

  always_comb begin
    scan_idx   = rr_ptr_q;
    scan_owner = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req[scan_idx]) begin
        scan_owner = scan_idx;
        found      = 1'b1;
      end
      scan_idx = inc_idx(scan_idx);
    end
  end

  always_comb begin
    bus.ack = '0;
    if (accept) bus.ack[owner] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    wr_en_d     = accept;
    data_in_d   = accept ? bus.req_data[owner*FIFO_WIDTH +: FIFO_WIDTH] : data_in_q;

    // Owner dropped its request: release, and a fresh selection may win below.
    if (state_q == BURST && !bus.req[grant_id_q]) begin
      state_d     = IDLE;
      rr_ptr_d    = inc_idx(grant_id_q);
      burst_cnt_d = '0;
    end

    if (accept && !hold) begin
      grant_id_d = owner;
      if (MAX_BURST == 1) begin
        rr_ptr_d    = inc_idx(owner);
        burst_cnt_d = '0;
      end else begin
        state_d     = BURST;
        burst_cnt_d = CW'(1);
      end
    end else if (accept && hold) begin
      if (burst_cnt_q == LAST_BEAT) begin
        state_d     = IDLE;
        rr_ptr_d    = inc_idx(grant_id_q);
        burst_cnt_d = '0;
      end else begin
        burst_cnt_d = burst_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
      wr_en_q     <= 1'b0;
      data_in_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      wr_en_q     <= wr_en_d;
      data_in_q   <= data_in_d;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.data_in  = data_in_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = (state_q == BURST);

  assign dbg_state_o     = state_q;
  assign dbg_burst_cnt_o = burst_cnt_q;
  assign dbg_rr_ptr_o    = rr_ptr_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a holder/beat-count model predicts every output each cycle.
module tb_fifo_write_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int MAXB = 4;

  logic       clk;
  logic       rst;
  logic       dbg_state;
  logic [2:0] dbg_cnt;
  logic [1:0] dbg_rr;

  int errors = 0;
  int checks = 0;

  // Model: who holds the port, beats taken in this grant, scan start, pending write.
  int         m_rr, m_holder, m_cnt, m_gid;
  bit         m_wr;
  logic [W-1:0] m_data;
  logic [W-1:0] prod [NREQ];

  fifo_write_arbiter_if #(.NUM_REQ(NREQ), .FIFO_WIDTH(W)) bus ();

  fifo_write_arbiter #(.NUM_REQ(NREQ), .FIFO_WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .dbg_state_o     (dbg_state),
    .dbg_burst_cnt_o (dbg_cnt),
    .dbg_rr_ptr_o    (dbg_rr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_holder = -1; m_cnt = 0; m_gid = 0; m_wr = 1'b0; m_data = '0;
  endtask

  // Drive one cycle of inputs, compare at negedge, advance model, return at posedge+1.
  task automatic step(input logic [3:0] r, input logic f, input logic af);
    int owner;
    bit acc;
    logic [3:0] exp_ack;
    bus.req = r;
    bus.fifo_full = f;
    bus.fifo_almostfull = af;
    for (int k = 0; k < NREQ; k++) bus.req_data[k*W +: W] = prod[k];
    @(negedge clk);
    owner = -1;
    if (m_holder >= 0 && r[m_holder]) owner = m_holder;
    else begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_rr + i) % NREQ;
        if (owner < 0 && r[k]) owner = k;
      end
    end
    acc = (owner >= 0) && !f && !(m_wr && af);
    exp_ack = acc ? 4'(1 << owner) : 4'b0000;
    check("ack", bus.ack, exp_ack);
    check("wr_en", bus.wr_en, m_wr);
    check("data_in", bus.data_in, m_data);
    check("grant_id", bus.grant_id, m_gid);
    check("busy", bus.busy, m_holder >= 0);
    check("burst_cnt", dbg_cnt, m_cnt);
    if (m_holder >= 0 && !r[m_holder]) begin
      m_rr = (m_holder + 1) % NREQ; m_holder = -1; m_cnt = 0;
    end
    m_wr = acc;
    if (acc) begin
      m_data = prod[owner];
      prod[owner] = prod[owner] + 1'b1;
      if (owner == m_holder) begin
        m_cnt++;
        if (m_cnt == MAXB) begin
          m_rr = (m_holder + 1) % NREQ; m_holder = -1; m_cnt = 0;
        end
      end else begin
        m_gid = owner;
        if (MAXB == 1) begin
          m_rr = (owner + 1) % NREQ; m_cnt = 0;
        end else begin
          m_holder = owner; m_cnt = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.fifo_full = 1'b0;
    bus.fifo_almostfull = 1'b0;
    for (int k = 0; k < NREQ; k++) prod[k] = W'(16'h1000 * (k + 1));
    model_reset();

    @(negedge clk);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_data_in", bus.data_in, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single requester 2, three beats, then release.
    prod[2] = 16'hA5A5;
    step(4'b0100, 0, 0);
    check("t2_wr_en", bus.wr_en, 1);
    check("t2_data0", bus.data_in, 16'hA5A5);
    check("t2_gid", bus.grant_id, 2);
    check("t2_busy", bus.busy, 1);
    step(4'b0100, 0, 0);
    step(4'b0100, 0, 0);
    check("t2_data2", bus.data_in, 16'hA5A7);
    step(4'b0000, 0, 0);
    check("t2_rel_busy", bus.busy, 0);
    check("t2_rel_wr_en", bus.wr_en, 0);
    check("t2_rel_rr", dbg_rr, 3);

    // Wrap 3 -> 0, requester 3 drops early and 0 is taken the same cycle.
    step(4'b1001, 0, 0);
    check("t6_gid3", bus.grant_id, 3);
    check("t6_data3", bus.data_in, 16'h4000);
    step(4'b1001, 0, 0);
    step(4'b0001, 0, 0);
    check("t6_gid0", bus.grant_id, 0);
    check("t6_data0", bus.data_in, 16'h1000);
    check("t6_busy", bus.busy, 1);
    step(4'b0000, 0, 0);

    // Reset mid-burst with everyone requesting.
    step(4'b1111, 0, 0);
    step(4'b1111, 0, 0);
    rst = 1'b1;
    #1;
    check("t1_wr_en", bus.wr_en, 0);
    check("t1_ack", bus.ack, 0);
    check("t1_busy", bus.busy, 0);
    check("t1_gid", bus.grant_id, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Contention between 0 and 1: bursts of four, back to back.
    for (int n = 1; n <= 9; n++) begin
      step(4'b0011, 0, 0);
      if (n == 4) check("t3_gid_b4", bus.grant_id, 0);
      if (n == 5) check("t3_gid_b5", bus.grant_id, 1);
      if (n == 9) begin
        check("t3_gid_b9", bus.grant_id, 0);
        check("t3_data_b9", bus.data_in, 16'h1005);
      end
    end

    // FIFO full stalls the burst of requester 0.
    repeat (5) step(4'b0011, 1, 0);
    check("t4_wr_en", bus.wr_en, 0);
    check("t4_gid", bus.grant_id, 0);
    check("t4_cnt", dbg_cnt, 1);
    check("t4_busy", bus.busy, 1);
    step(4'b0011, 0, 0);
    check("t4_resume_gid", bus.grant_id, 0);
    check("t4_resume_cnt", dbg_cnt, 2);
    check("t4_resume_data", bus.data_in, 16'h1006);

    // Almost full with a write in flight blocks one cycle only.
    step(4'b0011, 0, 1);
    check("t5_block_wr", bus.wr_en, 0);
    check("t5_block_cnt", dbg_cnt, 2);
    step(4'b0011, 0, 1);
    check("t5_accept_wr", bus.wr_en, 1);
    check("t5_accept_cnt", dbg_cnt, 3);
    check("t5_accept_data", bus.data_in, 16'h1007);
    step(4'b0011, 0, 0);
    check("t5_release_busy", bus.busy, 0);
    check("t5_release_rr", dbg_rr, 1);
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
